toggle_cover_collector: RTL and testbench



---
 rtl/toggle_cover_collector.sv | 90 +++++++++
 tb/tb_toggle_cover_collector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: sticky first-hit map, running covered count, and a
// valid/ready stream that reports each newly covered point, lowest index first.
module toggle_cover_collector #(
  parameter int              WIDTH       = 130,
  parameter longint unsigned COVER_INDEX = 64'd0,
  parameter int              CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic              gbl_clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  valid,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_index,
  output logic [CNT_W-1:0]  covered_count,
  output logic              all_covered
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] sel_onehot;
  logic [WIDTH-1:0] take_mask;
  logic [CNT_W-1:0] new_cnt;
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] sel_idx;
  logic             slot_free;
  logic             load;

  // A bit reports only on its first hit within a clear epoch.
  assign new_hits  = valid & ~covered;
  assign slot_free = !out_valid || out_ready;
  assign load      = slot_free && (pending != '0);

  // Two's-complement trick isolates the lowest set pending bit.
  assign sel_onehot = pending & (~pending + WIDTH'(1));
  assign take_mask  = load ? sel_onehot : '0;
  assign count_next = covered_count + new_cnt;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    new_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_cnt = new_cnt + CNT_W'(new_hits[i]);
    end
  end

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      // NOTE: the maps are plain flops with a real reset value; coverage must
      // start empty, so they are reset rather than treated as uninitialised RAM.
      covered       <= '0;
      pending       <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else if (clear) begin
      // out_index keeps its last value; same-cycle hits and handshakes are dropped.
      covered       <= '0;
      pending       <= '0;
      out_valid     <= 1'b0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      covered       <= covered | new_hits;
      pending       <= (pending & ~take_mask) | new_hits;
      covered_count <= count_next;
      all_covered   <= (count_next == CNT_W'(WIDTH));
      if (slot_free) begin
        out_valid <= load;
        if (load) out_index <= COVER_INDEX + 64'(sel_idx);
      end
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Bench for toggle_cover_collector: directed test-plan steps followed by random
// traffic, all checked cycle by cycle against a set/queue-based reference model.
module tb_toggle_cover_collector;

  localparam int              WIDTH = 130;
  localparam int              CNT_W = 8;
  localparam longint unsigned BASE  = 64'd100;

  logic              gbl_clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  valid;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_index;
  logic [CNT_W-1:0]  covered_count;
  logic              all_covered;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit          m_cov[WIDTH];
  int          pend[$];
  bit          m_ov;
  logic [63:0] m_oi;
  int          m_cnt;
  bit          m_all;

  logic [63:0] ev_q[$];

  toggle_cover_collector #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (BASE),
    .CNT_W       (CNT_W)
  ) dut (
    .gbl_clk       (gbl_clk),
    .reset         (reset),
    .valid         (valid),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  always #5 gbl_clk = ~gbl_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_cov[i]) m_cov[i] = 1'b0;
    pend.delete();
    m_ov  = 1'b0;
    m_cnt = 0;
    m_all = 1'b0;
  endtask

  // Applies one rising edge of the specified behaviour using pre-edge inputs.
  task automatic model_update();
    if (!reset) begin
      model_clear();
      m_oi = '0;
    end else if (clear) begin
      model_clear();
    end else begin
      if (!m_ov || out_ready) begin
        if (pend.size() > 0) begin
          pend.sort();
          m_oi = BASE + 64'(pend[0]);
          pend.delete(0);
          m_ov = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (valid[i] && !m_cov[i]) begin
          m_cov[i] = 1'b1;
          pend.push_back(i);
          m_cnt++;
        end
      end
      m_all = (m_cnt == WIDTH);
    end
  endtask

  // One clock: log any handshake, advance model, compare outputs 1 time unit later.
  task automatic step();
    if (reset && !clear && out_valid && out_ready) ev_q.push_back(out_index);
    @(posedge gbl_clk);
    model_update();
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_index", out_index, m_oi);
    check("covered_count", 64'(covered_count), 64'(m_cnt));
    check("all_covered", 64'(all_covered), 64'(m_all));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    valid     = '1;
    out_ready = 1'b1;
    m_oi      = '0;
    model_clear();

    // 1. Reset held with all hits asserted.
    steps(2);
    reset = 1'b1;
    valid = '0;
    steps(3);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset count", 64'(covered_count), 64'd0);

    // 2. Single hit on bit 5.
    ev_q.delete();
    valid[5] = 1'b1;
    step();
    valid = '0;
    check("single t+1 valid", 64'(out_valid), 64'd0);
    check("single t+1 count", 64'(covered_count), 64'd1);
    step();
    check("single t+2 valid", 64'(out_valid), 64'd1);
    check("single t+2 index", out_index, 64'd105);
    step();
    check("single t+3 valid", 64'(out_valid), 64'd0);
    valid[5] = 1'b1;
    step();
    valid = '0;
    steps(3);
    check("rehit events", 64'(ev_q.size()), 64'd1);

    // 3. Three simultaneous hits drain in ascending order.
    ev_q.delete();
    valid[129] = 1'b1;
    valid[0]   = 1'b1;
    valid[64]  = 1'b1;
    step();
    valid = '0;
    check("simul count", 64'(covered_count), 64'd4);
    steps(5);
    check("simul events", 64'(ev_q.size()), 64'd3);
    if (ev_q.size() == 3) begin
      check("simul ev0", ev_q[0], 64'd100);
      check("simul ev1", ev_q[1], 64'd164);
      check("simul ev2", ev_q[2], 64'd229);
    end

    // 4. Backpressure with repeated hits on an already-covered bit.
    ev_q.delete();
    valid[3] = 1'b1;
    valid[7] = 1'b1;
    step();
    valid     = '0;
    out_ready = 1'b0;
    steps(6);
    check("bp hold valid", 64'(out_valid), 64'd1);
    check("bp hold index", out_index, 64'd103);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      valid[3] = k[0];
      step();
    end
    valid = '0;
    check("bp events", 64'(ev_q.size()), 64'd2);
    if (ev_q.size() == 2) begin
      check("bp ev0", ev_q[0], 64'd103);
      check("bp ev1", ev_q[1], 64'd107);
    end

    // 5. Full coverage from an empty map.
    clear = 1'b1;
    step();
    clear = 1'b0;
    ev_q.delete();
    valid = '1;
    step();
    valid = '0;
    check("full count", 64'(covered_count), 64'd130);
    check("full all", 64'(all_covered), 64'd1);
    steps(WIDTH + 4);
    check("full events", 64'(ev_q.size()), 64'd130);
    if (ev_q.size() == WIDTH) begin
      for (int k = 0; k < WIDTH; k++) begin
        n_tests++;
        assert (ev_q[k] === 64'(100 + k)) else begin
          n_fail++;
          $error("FAIL full ev%0d: observed %0d expected %0d", k, ev_q[k], 100 + k);
        end
      end
    end

    // 6. Clear in the middle of a full drain.
    clear = 1'b1;
    step();
    clear = 1'b0;
    valid = '1;
    step();
    valid = '0;
    steps(20);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr valid", 64'(out_valid), 64'd0);
    check("clr count", 64'(covered_count), 64'd0);
    check("clr all", 64'(all_covered), 64'd0);
    ev_q.delete();
    valid[5] = 1'b1;
    step();
    valid = '0;
    steps(4);
    check("clr rehit events", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() == 1) check("clr rehit index", ev_q[0], 64'd105);

    // Random traffic: sparse hits, random backpressure, occasional clear/reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++) valid[i] = ($urandom_range(47) == 0);
      out_ready = ($urandom_range(3) != 0);
      clear     = ($urandom_range(249) == 0);
      reset     = ($urandom_range(799) != 0);
      step();
    end
    reset = 1'b1;
    clear = 1'b0;
    valid = '0;
    out_ready = 1'b1;
    steps(WIDTH + 4);
    check("final drained", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
